// File: rtl/i2si_deserializer.sv
// I2S receiver: recovers left/right words from sampled sd/ws and
// publishes each complete pair through an rts/rtr handshake.
module i2si_deserializer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i2si_sck_transition,
   input  logic             i2si_sd,
   input  logic             i2si_ws,
   input  logic             rtr,
   output logic [WIDTH-1:0] i2si_lft,
   output logic [WIDTH-1:0] i2si_rgt,
   output logic             rts,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      UNSYNC,
      LEFT,
      RIGHT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] left_q, left_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ws_prev_q;

   logic             boundary;
   logic             take;
   logic [WIDTH-1:0] shift_nx;
   logic [CW-1:0]    cnt_inc;
   logic             complete;
   logic             publish;
   logic             ferr_d;
   logic             rts_d;
   logic             ovr_d;

   assign boundary = i2si_sck_transition && (i2si_ws != ws_prev_q);
   assign take     = cnt_q < CW'(WIDTH);
   assign shift_nx = take ? {shift_q[WIDTH-2:0], i2si_sd} : shift_q;
   assign cnt_inc  = take ? cnt_q + CW'(1) : cnt_q;
   assign complete = cnt_inc == CW'(WIDTH);

   // Slot framing: shift bits, detect boundaries, track channel state
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      publish = 1'b0;
      ferr_d  = 1'b0;
      if (i2si_sck_transition) begin
         shift_d = shift_nx;
         cnt_d   = cnt_inc;
         if (boundary) begin
            cnt_d = '0;
            unique case (state_q)
               UNSYNC: begin
                  if (!i2si_ws) state_d = LEFT;
               end
               LEFT: begin
                  if (complete) begin
                     left_d  = shift_nx;
                     state_d = RIGHT;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = UNSYNC;
                  end
               end
               RIGHT: begin
                  if (complete) begin
                     publish = 1'b1;
                     state_d = LEFT;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = UNSYNC;
                  end
               end
               default: state_d = UNSYNC;
            endcase
         end
      end
   end

   // Handshake: publish raises rts, rtr retires it, unread pair flags overrun
   always_comb begin
      rts_d = rts;
      ovr_d = 1'b0;
      if (publish) begin
         rts_d = 1'b1;
         ovr_d = rts && !rtr;
      end else if (rts && rtr) begin
         rts_d = 1'b0;
      end
   end

   // Framing state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UNSYNC;
         shift_q   <= '0;
         left_q    <= '0;
         cnt_q     <= '0;
         ws_prev_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         left_q  <= left_d;
         cnt_q   <= cnt_d;
         if (i2si_sck_transition) ws_prev_q <= i2si_ws;
      end
   end

   // Output registers: words change only on publish
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i2si_lft  <= '0;
         i2si_rgt  <= '0;
         rts       <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (publish) begin
            i2si_lft <= left_q;
            i2si_rgt <= shift_nx;
         end
         rts       <= rts_d;
         overrun   <= ovr_d;
         frame_err <= ferr_d;
      end
   end

endmodule

// File: tb/tb_i2si_deserializer.sv
// Bench for i2si_deserializer: queue-based frame model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_i2si_deserializer;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         sck_t = 1'b0;
   logic         sd = 1'b0;
   logic         ws = 1'b0;
   logic         rtr = 1'b0;
   logic [W-1:0] lft, rgt;
   logic         rts, overrun, frame_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   i2si_deserializer #(.WIDTH(W)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i2si_sck_transition (sck_t),
      .i2si_sd             (sd),
      .i2si_ws             (ws),
      .rtr                 (rtr),
      .i2si_lft            (lft),
      .i2si_rgt            (rgt),
      .rts                 (rts),
      .overrun             (overrun),
      .frame_err           (frame_err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit           mq[$];
   int           m_phase = 0;
   logic         m_wsp = 1'b0;
   logic [W-1:0] m_held = '0;
   logic [W-1:0] e_lft = '0, e_rgt = '0;
   logic         e_rts = 1'b0, e_ovr = 1'b0, e_ferr = 1'b0;
   int           n_pub = 0, n_ovr = 0, n_ferr = 0;

   initial forever begin
      logic         pub;
      logic [W-1:0] word;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete();
         m_phase = 0;
         m_wsp   = 1'b0;
         m_held  = '0;
         e_lft   = '0;
         e_rgt   = '0;
         e_rts   = 1'b0;
         e_ovr   = 1'b0;
         e_ferr  = 1'b0;
      end else begin
         pub    = 1'b0;
         word   = '0;
         e_ovr  = 1'b0;
         e_ferr = 1'b0;
         if (sck_t) begin
            mq.push_back(sd);
            if (ws !== m_wsp) begin
               for (int i = 0; i < W && i < mq.size(); i++)
                  word[W-1-i] = mq[i];
               if (m_phase == 0) begin
                  if (ws == 1'b0) m_phase = 1;
               end else if (mq.size() < W) begin
                  e_ferr = 1'b1;
                  n_ferr++;
                  m_phase = 0;
               end else if (m_phase == 1) begin
                  m_held  = word;
                  m_phase = 2;
               end else begin
                  pub     = 1'b1;
                  m_phase = 1;
               end
               mq.delete();
            end
            m_wsp = ws;
         end
         if (pub) begin
            if (e_rts && !rtr) begin
               e_ovr = 1'b1;
               n_ovr++;
            end
            e_lft = m_held;
            e_rgt = word;
            e_rts = 1'b1;
            n_pub++;
         end else if (e_rts && rtr) begin
            e_rts = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int d_rts_hi = 0, d_ovr = 0, d_ferr = 0;

   initial forever begin
      @(negedge clk);
      chk("lft", 32'(lft), 32'(e_lft));
      chk("rgt", 32'(rgt), 32'(e_rgt));
      chk("rts", 32'(rts), 32'(e_rts));
      chk("overrun", 32'(overrun), 32'(e_ovr));
      chk("frame_err", 32'(frame_err), 32'(e_ferr));
      if (rts === 1'b1) d_rts_hi++;
      if (overrun === 1'b1) d_ovr++;
      if (frame_err === 1'b1) d_ferr++;
   end

   // ---------------- stimulus ----------------
   logic pend = 1'b0;
   logic pend_sd = 1'b0;
   logic rtr_pulse = 1'b0;
   int   gap = 2;

   task automatic sample(input logic w, input logic b);
      @(negedge clk);
      ws    = w;
      sd    = b;
      sck_t = 1'b1;
      if (rtr_pulse) rtr = 1'b1;
      @(negedge clk);
      sck_t = 1'b0;
      if (rtr_pulse) begin
         rtr       = 1'b0;
         rtr_pulse = 1'b0;
      end
      repeat (gap) begin
         @(negedge clk);
         ws = 1'($urandom_range(0, 1));
         sd = 1'($urandom_range(0, 1));
      end
   endtask

   // ws leads data by one sck: each bit goes out with the next bit's ws
   task automatic put(input logic w, input logic b);
      if (pend) sample(w, pend_sd);
      pend_sd = b;
      pend    = 1'b1;
   endtask

   task automatic flush(input logic w);
      if (pend) sample(w, pend_sd);
      pend = 1'b0;
   endtask

   task automatic slot(input logic w, input logic [31:0] d, input int len);
      for (int i = 0; i < len; i++) put(w, d[len-1-i]);
   endtask

   task automatic frame(input logic [31:0] l, input int ll,
                        input logic [31:0] r, input int rl);
      slot(1'b0, l, ll);
      slot(1'b1, r, rl);
   endtask

   int p0;

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_lft", 32'(lft), 32'h0);
      chk("rst_rgt", 32'(rgt), 32'h0);
      chk("rst_rts", 32'(rts), 32'h0);
      chk("rst_ovr", 32'(overrun), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      rst_n = 1'b1;

      // three 16-bit frames, first one lost to sync
      rtr = 1'b1;
      repeat (3) frame(32'hA5C3, 16, 32'h1234, 16);
      flush(1'b0);
      repeat (3) @(negedge clk);
      chk("t1_npub", n_pub, 2);
      chk("t1_lft", 32'(lft), 32'hA5C3);
      chk("t1_rgt", 32'(rgt), 32'h1234);
      chk("t1_rts_pulses", d_rts_hi, 2);

      // 32-bit slots, extra bits dropped
      repeat (2) frame(32'hFFFF_0000, 32, 32'h8001_FFFF, 32);
      flush(1'b0);
      repeat (3) @(negedge clk);
      chk("t2_npub", n_pub, 4);
      chk("t2_lft", 32'(lft), 32'hFFFF);
      chk("t2_rgt", 32'(rgt), 32'h8001);
      chk("t2_ferr", d_ferr, 0);

      // consumer stalled across two pairs
      rtr = 1'b0;
      frame(32'h0001, 16, 32'h0002, 16);
      flush(1'b0);
      frame(32'h0003, 16, 32'h0004, 16);
      flush(1'b0);
      chk("t3_rts", 32'(rts), 32'h1);
      chk("t3_novr", n_ovr, 1);
      chk("t3_dovr", d_ovr, 1);
      chk("t3_lft", 32'(lft), 32'h0003);
      chk("t3_rgt", 32'(rgt), 32'h0004);
      rtr = 1'b1;
      @(negedge clk);
      rtr = 1'b0;
      chk("t3_rts_clr", 32'(rts), 32'h0);

      // short right slot, resync, then a good frame
      rtr = 1'b1;
      p0 = n_pub;
      frame(32'h00AA, 16, 32'h0155, 10);
      flush(1'b0);
      chk("t4_dferr", d_ferr, 1);
      chk("t4_nferr", n_ferr, 1);
      frame(32'h1111, 16, 32'h2222, 16);
      flush(1'b0);
      chk("t4_nopub", n_pub - p0, 0);
      frame(32'hBEEF, 16, 32'hCAFE, 16);
      flush(1'b0);
      repeat (2) @(negedge clk);
      chk("t4_npub", n_pub - p0, 1);
      chk("t4_lft", 32'(lft), 32'hBEEF);
      chk("t4_rgt", 32'(rgt), 32'hCAFE);

      // rtr coincident with a publish while rts is high
      rtr = 1'b0;
      frame(32'h0A0A, 16, 32'h0B0B, 16);
      flush(1'b0);
      chk("t5_rts_a", 32'(rts), 32'h1);
      frame(32'h0C0C, 16, 32'h0D0D, 16);
      rtr_pulse = 1'b1;
      flush(1'b0);
      repeat (2) @(negedge clk);
      chk("t5_rts_b", 32'(rts), 32'h1);
      chk("t5_dovr", d_ovr, 1);
      chk("t5_lft", 32'(lft), 32'h0C0C);
      chk("t5_rgt", 32'(rgt), 32'h0D0D);
      rtr = 1'b1;
      @(negedge clk);
      rtr = 1'b0;

      // reset in the middle of a left word
      for (int i = 0; i < 8; i++) put(1'b0, 1'(i));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_lft", 32'(lft), 32'h0);
      chk("t6_rgt", 32'(rgt), 32'h0);
      chk("t6_rts", 32'(rts), 32'h0);
      pend = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rtr   = 1'b1;
      p0    = n_pub;
      frame(32'h1357, 16, 32'h2468, 16);
      flush(1'b0);
      chk("t6_nopub", n_pub - p0, 0);
      chk("t6_lft0", 32'(lft), 32'h0);
      frame(32'h9ABC, 16, 32'hDEF0, 16);
      flush(1'b0);
      repeat (2) @(negedge clk);
      chk("t6_npub", n_pub - p0, 1);
      chk("t6_lft1", 32'(lft), 32'h9ABC);
      chk("t6_rgt1", 32'(rgt), 32'hDEF0);
      chk("end_dferr", d_ferr, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2si_deserializer.md
Name: i2si_deserializer

Overview:
- I2S receive-side block: samples serial data and word select on sck rising-edge pulses, and recovers WIDTH-bit left/right words.
- Publishes each complete left/right pair as parallel words, using an rts/rtr handshake toward the downstream consumer.
- Sits between the I2S input pins (after sck edge detection) and the audio processing path.
- Mirrors the output serializer's framing: left channel when ws=0; ws changes one sck before the MSB; MSB first.

Parameters:
WIDTH, 16, bits per channel word captured (MSB-justified; extra slot bits ignored)

Ports:
clk  input  1  master clock
rst_n  input  1  asynchronous active-low reset
i2si_sck_transition  input  1  one-clk pulse when sck goes low to high; all sampling is qualified by it
i2si_sd  input  1  I2S serial data, already synchronized to clk
i2si_ws  input  1  I2S word select, already synchronized to clk (0 = left, 1 = right)
rtr  input  1  consumer ready to receive; acknowledges the current pair
i2si_lft  output  WIDTH  last complete left word
i2si_rgt  output  WIDTH  last complete right word
rts  output  1  ready to send; high while an unacknowledged pair is held
overrun  output  1  one-clk pulse: new pair overwrote an unacknowledged pair
frame_err  output  1  one-clk pulse: a channel slot ended with fewer than WIDTH bits

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low.
- Reset state:
  - state=UNSYNC; shift register, bit counter, left holding register and ws_prev all 0.
  - i2si_lft=0, i2si_rgt=0, rts=0, overrun=0, frame_err=0.
- Reset asserted mid-frame discards the partial word and any held pair.
- Sampling: only on clk edges with i2si_sck_transition=1. Each such edge samples sd and ws; ws_prev <= sampled ws.
- Boundary: sampled ws != ws_prev.
  - The sd bit sampled at a boundary is the LSB of the channel selected by ws_prev.
- Bit counter (0..WIDTH, saturating) counts bits of the current slot, including the boundary bit.
  - While count < WIDTH, sd shifts into the LSB of the shift register (MSB first).
  - Bits beyond WIDTH are dropped.
- At a boundary, cnt_new = count + 1, saturated at WIDTH.
  - If cnt_new == WIDTH: the word (including the boundary bit) is complete for channel ws_prev.
  - Otherwise: frame_err pulses for one clk, the word is discarded, and the state returns to UNSYNC.
- After every boundary, counter = 0.
- States:
  - UNSYNC: ignore data. On a boundary with ws 1->0 (right ended), go to LEFT with counter=0. No frame_err is raised from UNSYNC.
  - LEFT: on a boundary (0->1) with a complete word, latch it into the left holding register and go to RIGHT.
  - RIGHT: on a boundary (1->0) with a complete word, publish the pair and go to LEFT.
- Publish (registered, on the same clk edge as the boundary sample):
  - i2si_lft <= left holding register; i2si_rgt <= completed right word; rts <= 1.
  - Outputs are visible the clk after the transition pulse.
- Handshake:
  - rts=1 and rtr=1 on a clk edge with no publish: rts <= 0 at that edge.
  - Publish with rts=0: rts <= 1, no overrun.
  - Publish with rts=1 and rtr=1 in the same clk: new data is loaded, rts stays 1, no overrun.
  - Publish with rts=1 and rtr=0: data is overwritten, rts stays 1, overrun pulses for 1 clk.
  - rtr while rts=0: ignored.
- i2si_lft and i2si_rgt are stable except at publish.
- Only whole pairs are published; a frame error between left and right drops the held left word.
- sd/ws changes between transition pulses have no effect.

Test Plan:
- Reset then 3 frames (WIDTH=16, L=16'hA5C3, R=16'h1234, 16-bit slots), rtr tied 1 -> first frame after the first ws 1->0 is dropped (sync); then i2si_lft=A5C3, i2si_rgt=1234, rts pulses one clk per frame.
- 32-bit slots (L=16'hFFFF then 16 zero bits, R=16'h8001 then 16 ones), rtr=1 -> outputs FFFF/8001; extra bits ignored; frame_err never asserts.
- rtr held 0 across two frames (L1=0001/R1=0002, L2=0003/R2=0004) -> rts stays 1; overrun pulses once at the second publish; outputs 0003/0004. Then rtr=1 for one clk -> rts=0 the next clk.
- Right slot cut to 10 bits -> frame_err pulses once; no publish; state UNSYNC. Resync on the next ws 1->0; the following full frame publishes correctly.
- rtr asserted in the same clk as a publish while rts=1 -> new pair loaded, rts remains 1, no overrun.
- rst_n pulsed low mid-left-word -> all outputs 0 immediately (async); no publish until a full sync plus one complete L/R frame.
